// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   DWIDTH_DAT     : default data/instruction/PC width
//   INST_START_DEF : default fetch address after reset
//   fetch_state_e  : fetch FSM state encoding
package fetch_unit_pkg;
  localparam int          DWIDTH_DAT     = 16;
  localparam logic [15:0] INST_START_DEF = 16'h0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // free to issue a request
    WAIT  = 2'd1,  // one live request outstanding
    DRAIN = 2'd2   // one stale request outstanding, its data is dropped
  } fetch_state_e;
endpackage

// File: rtl/fetch_queue.sv
// Two-entry instruction buffer holding {instruction, pc} pairs.
//   clk, rst              : clock, async active-high reset
//   push_i/push_inst_i/   : write one entry at the tail
//   push_pc_i
//   pop_i                 : retire the head entry
//   flush_i               : drop all entries (wins over push/pop)
//   head_inst_o/head_pc_o : head entry (combinational select)
//   empty_o/full_o/count_o: occupancy
module fetch_queue #(
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DWIDTH-1:0] push_inst_i,
  input  logic [DWIDTH-1:0] push_pc_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [DWIDTH-1:0] head_inst_o,
  output logic [DWIDTH-1:0] head_pc_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [1:0]        count_o
);
  logic [DWIDTH-1:0] inst_q [2];
  logic [DWIDTH-1:0] pc_q   [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        inst_q[wr_ptr_q] <= push_inst_i;
        pc_q[wr_ptr_q]   <= push_pc_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push_i) - 2'(pop_i);
    end
  end

  assign head_inst_o = inst_q[rd_ptr_q];
  assign head_pc_o   = pc_q[rd_ptr_q];
  assign empty_o     = (count_q == 2'd0);
  assign full_o      = (count_q == 2'd2);
  assign count_o     = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding word reads into a 2-entry
// queue, valid/ready issue to decode, and the register-file PC write port.
//   clk, rst                          : clock, async active-high reset
//   imem_req/imem_addr/imem_gnt       : request channel to instruction memory
//   imem_rvalid/imem_rdata            : response channel
//   inst_valid/inst_ready/inst_out/   : issue handshake to decode
//   inst_pc
//   redirect/redirect_pc              : taken branch/jump from execute
//   pc_in/pc_en                       : register file PC write port
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                DWIDTH     = DWIDTH_DAT,
  parameter logic [DWIDTH-1:0] INST_START = DWIDTH'(INST_START_DEF),
  parameter int                QDEPTH     = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [DWIDTH-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DWIDTH-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DWIDTH-1:0] inst_out,
  output logic [DWIDTH-1:0] inst_pc,
  input  logic              redirect,
  input  logic [DWIDTH-1:0] redirect_pc,
  output logic [DWIDTH-1:0] pc_in,
  output logic              pc_en
);
  fetch_state_e      state_q, state_d;
  logic [DWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DWIDTH-1:0] req_pc_q, req_pc_d;   // address of the outstanding request

  logic              q_push, q_pop, q_flush, q_empty, q_full;
  logic [1:0]        q_count;
  logic [DWIDTH-1:0] q_head_inst, q_head_pc;
  logic              outstanding, gnt;

  fetch_queue #(.DWIDTH(DWIDTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push_i     (q_push),
    .push_inst_i(imem_rdata),
    .push_pc_i  (req_pc_q),
    .pop_i      (q_pop),
    .flush_i    (q_flush),
    .head_inst_o(q_head_inst),
    .head_pc_o  (q_head_pc),
    .empty_o    (q_empty),
    .full_o     (q_full),
    .count_o    (q_count)
  );

  assign outstanding = (state_q != FETCH);
  // Counting the outstanding slot guarantees a response always has room.
  assign imem_req    = !rst && (state_q == FETCH) && !q_full &&
                       (({1'b0, q_count} + {2'b0, outstanding}) < 3'(QDEPTH));
  assign imem_addr   = fetch_pc_q;
  assign gnt         = imem_req && imem_gnt;

  assign inst_valid  = !q_empty;
  assign inst_out    = inst_valid ? q_head_inst : '0;
  assign inst_pc     = inst_valid ? q_head_pc   : '0;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    q_push     = 1'b0;
    q_pop      = 1'b0;
    q_flush    = 1'b0;
    pc_en      = 1'b0;
    pc_in      = '0;
    if (redirect) begin
      // Redirect overrides pop and push; a request still in flight (or
      // granted right now) must have its response swallowed in DRAIN.
      // This also keeps a redirect in DRAIN in DRAIN unless the stale
      // response lands in the same cycle.
      q_flush    = 1'b1;
      fetch_pc_d = redirect_pc;
      pc_en      = 1'b1;
      pc_in      = redirect_pc;
      if ((outstanding && !imem_rvalid) || gnt) state_d = DRAIN;
      else                                      state_d = FETCH;
    end else begin
      q_pop = inst_valid && inst_ready;
      if (q_pop) begin
        pc_en = 1'b1;
        pc_in = q_head_pc + DWIDTH'(1);
      end
      case (state_q)
        FETCH: if (gnt) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + DWIDTH'(1);
          state_d    = WAIT;
        end
        WAIT: if (imem_rvalid) begin
          q_push  = 1'b1;
          state_d = FETCH;
        end
        DRAIN: if (imem_rvalid) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end
    if (rst) begin
      pc_en = 1'b0;
      pc_in = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= INST_START;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [15:0] imem_addr, imem_rdata = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [15:0] inst_out, inst_pc;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0, pc_in;
  logic        pc_en;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .pc_in(pc_in), .pc_en(pc_en)
  );

  int vecs = 0, errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  // Behavioural model: queue of fetched entries, one outstanding-request
  // record (with a stale flag once a redirect overtakes it), next fetch address.
  typedef struct { logic [15:0] inst; logic [15:0] pc; } ent_t;
  ent_t        m_q[$];
  bit          m_out, m_stale;
  logic [15:0] m_fpc, m_opc;

  // Memory responder
  bit          mem_pend, stray;
  int          mem_wait, lat_lo, lat_hi, gnt_pct;
  logic [15:0] mem_addr;

  // Observations of the DUT
  logic [15:0] issue_log[$], pcin_log[$], gnt_log[$];
  logic        d_req, d_valid, d_pcen;
  logic [15:0] d_addr, d_ipc, d_pcin;

  task automatic clear_logs();
    issue_log.delete(); pcin_log.delete(); gnt_log.delete();
  endtask

  task automatic cycle(input bit rdy, input bit redir, input logic [15:0] rpc);
    bit          ereq, g, rv, epcen;
    logic [15:0] rd, epcin;
    ent_t        e;
    @(negedge clk);
    ereq = !m_out && (m_q.size() < 2);
    g    = ereq && ($urandom_range(99) < gnt_pct);
    rv   = (mem_pend && mem_wait == 0) || stray;
    rd   = rv ? (mem_pend ? mdata(mem_addr) : 16'hDEAD) : 16'($urandom);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    inst_ready = rdy; redirect = redir; redirect_pc = rpc;
    #1;
    d_req = imem_req; d_addr = imem_addr; d_valid = inst_valid;
    d_ipc = inst_pc; d_pcen = pc_en; d_pcin = pc_in;
    chk("imem_req", 32'(imem_req), 32'(ereq));
    if (ereq) chk("imem_addr", 32'(imem_addr), 32'(m_fpc));
    chk("inst_valid", 32'(inst_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("inst_out", 32'(inst_out), 32'(m_q[0].inst));
      chk("inst_pc", 32'(inst_pc), 32'(m_q[0].pc));
    end
    epcen = redir || (rdy && m_q.size() > 0);
    epcin = redir ? rpc : (epcen ? m_q[0].pc + 16'd1 : 16'd0);
    chk("pc_en", 32'(pc_en), 32'(epcen));
    chk("pc_in", 32'(pc_in), 32'(epcin));
    if (inst_valid && rdy && !redir) issue_log.push_back(inst_pc);
    if (pc_en) pcin_log.push_back(pc_in);
    if (g) gnt_log.push_back(imem_addr);
    @(posedge clk);
    if (redir) begin
      m_q.delete();
      if (m_out && !rv) m_stale = 1;
      else if (g) begin m_out = 1; m_stale = 1; end
      else m_out = 0;
      m_fpc = rpc;
    end else begin
      if (rdy && m_q.size() > 0) void'(m_q.pop_front());
      if (m_out && rv) begin
        if (!m_stale) begin e.inst = rd; e.pc = m_opc; m_q.push_back(e); end
        m_out = 0;
      end else if (g) begin
        m_out = 1; m_stale = 0; m_opc = m_fpc; m_fpc = m_fpc + 16'd1;
      end
    end
    if (rv && mem_pend) mem_pend = 0;
    else if (mem_pend) mem_wait--;
    if (g) begin mem_pend = 1; mem_addr = d_addr; mem_wait = $urandom_range(lat_hi, lat_lo); end
    stray = 0;
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_imem_req", 32'(imem_req), 0);
    chk("rst_imem_addr", 32'(imem_addr), 32'h0000);
    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_inst_out", 32'(inst_out), 0);
    chk("rst_inst_pc", 32'(inst_pc), 0);
    chk("rst_pc_en", 32'(pc_en), 0);
    chk("rst_pc_in", 32'(pc_in), 0);
    @(posedge clk);
    @(negedge clk);
    imem_gnt = 0; imem_rvalid = 0; redirect = 0;
    rst = 1'b0;
    m_q.delete(); m_out = 0; m_stale = 0; m_fpc = 16'h0000; mem_pend = 0; stray = 0;
    clear_logs();
  endtask

  initial begin
    bit          rdy, rd_en;
    logic [15:0] rpc;
    int          n;
    // 1: streaming with 1-cycle grant/response
    gnt_pct = 100; lat_lo = 0; lat_hi = 0;
    do_reset();
    for (int i = 0; i < 12; i++) cycle(1, 0, 0);
    chk("t1_pcin0", 32'(pcin_log[0]), 32'h1);
    chk("t1_pcin1", 32'(pcin_log[1]), 32'h2);
    chk("t1_pcin2", 32'(pcin_log[2]), 32'h3);
    chk("t1_iss0", 32'(issue_log[0]), 32'h0);
    chk("t1_iss2", 32'(issue_log[2]), 32'h2);
    chk("t1_gnt1", 32'(gnt_log[1]), 32'h1);

    // 2: decode stalled, queue fills and requests stop
    do_reset();
    for (int i = 0; i < 10; i++) cycle(0, 0, 0);
    chk("t2_req_off", 32'(d_req), 0);
    chk("t2_head_pc", 32'(d_ipc), 32'h0);
    chk("t2_valid", 32'(d_valid), 1);
    chk("t2_ngnt", 32'(gnt_log.size()), 2);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0);
    chk("t2_iss0", 32'(issue_log[0]), 32'h0);
    chk("t2_iss1", 32'(issue_log[1]), 32'h1);
    chk("t2_resume", 32'(gnt_log[2]), 32'h2);

    // 3: redirect while the request for address 3 is outstanding
    lat_lo = 4; lat_hi = 4;
    do_reset();
    n = 0;
    while (!(m_out && m_opc == 16'h3) && n < 80) begin cycle(1, 0, 0); n++; end
    chk("t3_reach", 32'(m_out && m_opc == 16'h3), 1);
    clear_logs();
    cycle(1, 1, 16'h0040);
    chk("t3_pcen", 32'(d_pcen), 1);
    chk("t3_pcin", 32'(d_pcin), 32'h0040);
    cycle(1, 0, 0);
    chk("t3_flushed", 32'(d_valid), 0);
    for (int i = 0; i < 20; i++) cycle(1, 0, 0);
    chk("t3_addr", 32'(gnt_log[0]), 32'h0040);
    chk("t3_iss", 32'(issue_log[0]), 32'h0040);

    // 4: redirect in the cycle that would pop inst_pc 5
    lat_lo = 0; lat_hi = 2;
    cycle(1, 1, 16'h0000);
    n = 0;
    while (!(m_q.size() > 0 && m_q[0].pc == 16'h5) && n < 80) begin cycle(1, 0, 0); n++; end
    chk("t4_reach", 32'(m_q.size() > 0 && m_q[0].pc == 16'h5), 1);
    clear_logs();
    cycle(1, 1, 16'h0100);
    chk("t4_pcin", 32'(d_pcin), 32'h0100);
    chk("t4_noissue", 32'(issue_log.size()), 0);
    for (int i = 0; i < 12; i++) cycle(1, 0, 0);
    chk("t4_next", 32'(issue_log[0]), 32'h0100);

    // 5: fetch address wraps
    cycle(1, 1, 16'hFFFF);
    clear_logs();
    for (int i = 0; i < 20; i++) cycle(1, 0, 0);
    chk("t5_gnt0", 32'(gnt_log[0]), 32'hFFFF);
    chk("t5_gnt1", 32'(gnt_log[1]), 32'h0000);
    chk("t5_iss0", 32'(issue_log[0]), 32'hFFFF);
    chk("t5_iss1", 32'(issue_log[1]), 32'h0000);

    // 6: async reset in WAIT with a queued entry, then a stray response
    lat_lo = 1; lat_hi = 3;
    n = 0;
    while (!(m_out && m_q.size() == 1) && n < 60) begin cycle(0, 0, 0); n++; end
    chk("t6_reach", 32'(m_out && m_q.size() == 1), 1);
    do_reset();
    stray = 1;
    cycle(1, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0);
    chk("t6_first", 32'(gnt_log[0]), 32'h0000);
    chk("t6_iss0", 32'(issue_log[0]), 32'h0000);

    // 7: random traffic
    gnt_pct = 60; lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      rdy   = ($urandom_range(99) < 70);
      rd_en = ($urandom_range(99) < 6);
      rpc   = ($urandom_range(3) == 0) ? 16'($urandom_range(16'hFFFF, 16'hFFFD)) : 16'($urandom);
      cycle(rdy, rd_en, rpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vecs);
    $fatal(1);
  end
endmodule
